// File: rtl/ysyx_23060136_exu_div_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_23060136_exu_div_ctrl
//   Issue/result controller between the EXU operand stage and the iterative
//   divider. It settles divide-by-zero and signed-overflow locally. It answers
//   a DIV/REM pair on identical operands from a one-entry result cache. Every
//   other request goes through the divider handshake. The selected result is
//   held until writeback accepts it.
//
// Ports
//   clk_i, rst_ni              clock, synchronous active-low reset
//   in_valid_i / in_ready_o    request handshake (ready only in IDLE)
//   in_op_i, in_word_i         00 DIV, 01 DIVU, 10 REM, 11 REMU; W variant
//   in_src1_i, in_src2_i       dividend, divisor
//   in_rd_i                    destination tag, passed through
//   flush_i                    kills the request in flight
//   out_valid_o / out_ready_i  result handshake
//   out_data_o, out_rd_o       result and its tag, held while out_valid_o
//   div_valid_o / div_ready_i  divider request handshake
//   div_divw_o, div_signed_o   divider mode
//   div_dividend_o/_divisor_o  registered operands for the divider
//   div_out_valid_i            one-cycle completion pulse
//   div_quotient_i/_remainder_i divider results, valid with the pulse
// ---------------------------------------------------------------------------
module ysyx_23060136_exu_div_ctrl #(
  parameter int XLEN     = 64,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      in_op_i,
  input  logic            in_word_i,
  input  logic [XLEN-1:0] in_src1_i,
  input  logic [XLEN-1:0] in_src2_i,
  input  logic [4:0]      in_rd_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_data_o,
  output logic [4:0]      out_rd_o,
  output logic            div_valid_o,
  input  logic            div_ready_i,
  output logic            div_divw_o,
  output logic            div_signed_o,
  output logic [XLEN-1:0] div_dividend_o,
  output logic [XLEN-1:0] div_divisor_o,
  input  logic            div_out_valid_i,
  input  logic [XLEN-1:0] div_quotient_i,
  input  logic [XLEN-1:0] div_remainder_i
);

  localparam int TAG_W = 2*XLEN + 2;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN
  } state_e;

  state_e            state_q;
  logic [1:0]        op_q;
  logic              word_q;
  logic              out_valid_q, div_valid_q, div_divw_q, div_signed_q;
  logic [XLEN-1:0]   out_data_q, dividend_q, divisor_q;
  logic [4:0]        out_rd_q;
  logic              cache_vld_q;
  logic [TAG_W-1:0]  cache_tag_q;
  logic [XLEN-1:0]   cache_quo_q, cache_rem_q;

  // W results are always the sign-extended low word, unsigned forms included.
  function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] v, input logic w);
    fmt = w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Classification of the incoming request
  logic             accept, is_zero, is_ovf, is_hit, fast;
  logic [TAG_W-1:0] in_tag;
  logic [XLEN-1:0]  fast_quo, fast_rem, fast_res, div_res;

  assign accept  = in_valid_i && in_ready_o && !flush_i;
  assign in_tag  = {in_src1_i, in_src2_i, in_word_i, in_op_i[0]};
  assign is_zero = in_word_i ? (in_src2_i[31:0] == 32'd0) : (in_src2_i == '0);
  assign is_ovf  = !in_op_i[0] &&
                   (in_word_i ? (in_src1_i[31:0] == 32'h8000_0000 &&
                                 in_src2_i[31:0] == 32'hFFFF_FFFF)
                              : (in_src1_i == MIN_NEG && in_src2_i == '1));
  assign is_hit  = CACHE_EN && cache_vld_q && (cache_tag_q == in_tag);
  assign fast    = is_zero || is_ovf || is_hit;

  always_comb begin
    fast_quo = cache_quo_q;
    fast_rem = cache_rem_q;
    if (is_zero) begin
      fast_quo = '1;
      fast_rem = in_src1_i;
    end else if (is_ovf) begin
      fast_quo = in_src1_i;
      fast_rem = '0;
    end
  end

  assign fast_res = fmt(in_op_i[1] ? fast_rem : fast_quo, in_word_i);
  assign div_res  = fmt(op_q[1] ? div_remainder_i : div_quotient_i, word_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      word_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_rd_q     <= '0;
      div_valid_q  <= 1'b0;
      div_divw_q   <= 1'b0;
      div_signed_q <= 1'b0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      cache_vld_q  <= 1'b0;
      cache_tag_q  <= '0;
      cache_quo_q  <= '0;
      cache_rem_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (accept) begin
          op_q     <= in_op_i;
          word_q   <= in_word_i;
          out_rd_q <= in_rd_i;
          if (fast) begin
            out_data_q  <= fast_res;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            div_valid_q  <= 1'b1;
            div_divw_q   <= in_word_i;
            div_signed_q <= ~in_op_i[0];
            dividend_q   <= in_src1_i;
            divisor_q    <= in_src2_i;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (flush_i) begin
            div_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end else if (div_ready_i) begin
            div_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush_i) begin
            // A pulse that coincides with the flush is the one DRAIN would wait for.
            state_q <= div_out_valid_i ? S_IDLE : S_DRAIN;
          end else if (div_out_valid_i) begin
            out_data_q  <= div_res;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
            if (CACHE_EN) begin
              cache_vld_q <= 1'b1;
              cache_tag_q <= {dividend_q, divisor_q, word_q, op_q[0]};
              cache_quo_q <= div_quotient_i;
              cache_rem_q <= div_remainder_i;
            end
          end
        end
        S_DONE: if (flush_i || out_ready_i) begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        S_DRAIN: if (div_out_valid_i) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o     = (state_q == S_IDLE);
  // A flush in ISSUE must not let the divider see a handshake that cycle.
  assign div_valid_o    = div_valid_q && !flush_i;
  assign div_divw_o     = div_divw_q;
  assign div_signed_o   = div_signed_q;
  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;
  assign out_valid_o    = out_valid_q;
  assign out_data_o     = out_data_q;
  assign out_rd_o       = out_rd_q;

endmodule

// File: tb/tb_ysyx_23060136_exu_div_ctrl.sv
module tb_ysyx_23060136_exu_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [1:0]  in_op = '0;
  logic        in_word = 1'b0;
  logic [63:0] in_src1 = '0, in_src2 = '0;
  logic [4:0]  in_rd = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic        div_valid, div_ready, div_divw, div_signed;
  logic [63:0] div_dividend, div_divisor;
  logic        div_out_valid;
  logic [63:0] div_quotient, div_remainder;

  int n_chk = 0, n_err = 0;
  int div_issues = 0;

  always #5 clk = ~clk;

  ysyx_23060136_exu_div_ctrl #(.XLEN(64), .CACHE_EN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op_i(in_op), .in_word_i(in_word),
    .in_src1_i(in_src1), .in_src2_i(in_src2), .in_rd_i(in_rd), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_rd_o(out_rd),
    .div_valid_o(div_valid), .div_ready_i(div_ready), .div_divw_o(div_divw),
    .div_signed_o(div_signed), .div_dividend_o(div_dividend), .div_divisor_o(div_divisor),
    .div_out_valid_i(div_out_valid), .div_quotient_i(div_quotient), .div_remainder_i(div_remainder)
  );

  // Behavioural iterative divider: 32/64-cycle latency, one-cycle result pulse.
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [63:0] m_q, m_r;
  assign div_ready = !m_busy;

  function automatic void div_calc(input logic [63:0] a0, input logic [63:0] b0,
                                   input logic w, input logic s,
                                   output logic [63:0] q, output logic [63:0] r);
    logic [63:0] a, b;
    a = w ? (s ? {{32{a0[31]}}, a0[31:0]} : {32'd0, a0[31:0]}) : a0;
    b = w ? (s ? {{32{b0[31]}}, b0[31:0]} : {32'd0, b0[31:0]}) : b0;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  always @(posedge clk) begin
    div_out_valid <= 1'b0;
    if (!rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy        <= 1'b0;
        div_out_valid <= 1'b1;
        div_quotient  <= m_q;
        div_remainder <= m_r;
      end else m_cnt <= m_cnt - 1;
    end else if (div_valid) begin
      logic [63:0] q, r;
      div_calc(div_dividend, div_divisor, div_divw, div_signed, q, r);
      m_q    <= q;
      m_r    <= r;
      m_busy <= 1'b1;
      m_cnt  <= div_divw ? 32 : 64;
      div_issues <= div_issues + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd);
    in_valid = 1'b1; in_op = op; in_word = w; in_src1 = a; in_src2 = b; in_rd = rd;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    if (!out_valid) chk("out_timeout", 64'd0, 64'd1);
  endtask

  task automatic hs(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_hs_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_hs_out_valid"}, {63'd0, out_valid}, 64'd0);
  endtask

  // Fast path: result must be valid one cycle after accept with no divider use.
  task automatic fast_case(input string tag, input logic [1:0] op, input logic w,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    int d0;
    d0 = div_issues;
    issue(op, w, a, b, 5'd9);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_nodiv"}, {63'd0, div_valid}, 64'd0);
    hs(tag);
    chk({tag, "_issues"}, 64'(div_issues - d0), 64'd0);
  endtask

  initial begin
    int cyc, d0;
    logic seen, bad;

    // Reset
    tick(); tick();
    rst = 1'b1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_div_valid", {63'd0, div_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_dividend", div_dividend, 64'd0);

    // DIV -7/2 through the divider, then REM from the cache
    issue(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3);
    chk("div_in_ready_low", {63'd0, in_ready}, 64'd0);
    chk("div_valid_n1", {63'd0, div_valid}, 64'd1);
    chk("div_signed", {63'd0, div_signed}, 64'd1);
    wait_out(cyc);
    chk("div_m7_2", out_data, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("div_rd", {59'd0, out_rd}, 64'd3);
    hs("div");
    fast_case("rem_hit", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);

    // Divide by zero
    fast_case("divu_z", 2'b01, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    fast_case("remw_z", 2'b10, 1'b1, 64'h5, 64'd0, 64'h5);

    // Signed overflow
    fast_case("div_ovf", 2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000);
    fast_case("divw_ovf", 2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
    fast_case("remw_ovf", 2'b10, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0);

    // DIVUW through the divider, then writeback backpressure
    issue(2'b01, 1'b1, 64'hFFFF_FFFF, 64'd1, 5'd17);
    chk("divuw_divw", {63'd0, div_divw}, 64'd1);
    chk("divuw_unsigned", {63'd0, div_signed}, 64'd0);
    wait_out(cyc);
    chk("divuw_latency", 64'((cyc >= 30 && cyc <= 40) ? 1 : 0), 64'd1);
    chk("divuw_data", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!out_valid || in_ready || out_data !== 64'hFFFF_FFFF_FFFF_FFFF || out_rd !== 5'd17)
        bad = 1'b1;
    end
    chk("divuw_hold_stable", {63'd0, bad}, 64'd0);
    chk("divuw_hold_rd", {59'd0, out_rd}, 64'd17);
    hs("divuw");

    // Flush during WAIT: drain the divider, no result, no cache write
    issue(2'b00, 1'b0, 64'd100, 64'd3, 5'd4);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drain_in_ready", {63'd0, in_ready}, 64'd0);
    seen = 1'b0; bad = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (out_valid || in_ready) bad = 1'b1;
      seen = div_out_valid;
      tick();
    end
    chk("drain_pulse_seen", {63'd0, seen}, 64'd1);
    chk("drain_quiet", {63'd0, bad}, 64'd0);
    chk("drain_idle", {63'd0, in_ready}, 64'd1);
    d0 = div_issues;
    issue(2'b10, 1'b0, 64'd100, 64'd3, 5'd5);
    chk("rem_after_flush_miss", {63'd0, div_valid}, 64'd1);
    wait_out(cyc);
    chk("rem_100_3", out_data, 64'd1);
    chk("rem_after_flush_issues", 64'(div_issues - d0), 64'd1);
    hs("rem");

    // Reset during WAIT
    issue(2'b00, 1'b0, 64'd1000, 64'd3, 5'd6);
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("wrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("wrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("wrst_div_valid", {63'd0, div_valid}, 64'd0);
    chk("wrst_out_data", out_data, 64'd0);
    chk("wrst_out_rd", {59'd0, out_rd}, 64'd0);
    chk("wrst_divisor", div_divisor, 64'd0);
    issue(2'b00, 1'b0, 64'd100, 64'd7, 5'd8);
    wait_out(cyc);
    chk("div_100_7", out_data, 64'd14);
    chk("div_100_7_rd", {59'd0, out_rd}, 64'd8);
    hs("d100");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_23060136_exu_div_ctrl.md
# ysyx_23060136_exu_div_ctrl

Divide issue/result controller between the EXU decode/operand stage and the iterative 64-bit divider. Accepts RV64M DIV/DIVU/REM/REMU and their W forms. Resolves divide-by-zero and signed-overflow cases without the divider, reuses a one-entry result cache for DIV/REM pairs on identical operands, and drives the divider handshake otherwise. Selects the quotient or remainder, sign-extends W results, and holds the result for the writeback handshake.

## Interface
- XLEN, 64: operand/result width.
- CACHE_EN, 1: 1 enables the one-entry result cache; 0 makes every lookup a miss.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; op[0]=1 means unsigned.
- in_word  in  1  W variant (32-bit operation).
- in_src1 / in_src2  in  XLEN  dividend / divisor.
- in_rd  in  5  destination tag, passed through.
- flush  in  1  pipeline kill; discards the request in flight.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback accepts.
- out_data  out  XLEN  result.
- out_rd  out  5  destination tag.
- div_valid  out  1  divider request.
- div_ready  in  1  divider idle.
- div_divw / div_signed  out  1  divider mode.
- div_dividend / div_divisor  out  XLEN  registered operands.
- div_out_valid  in  1  one-cycle completion pulse.
- div_quotient / div_remainder  in  XLEN  valid only during the div_out_valid cycle.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- Accept a request on in_valid && in_ready && !flush. Register op, word, operands and rd.
- Classification at accept, using the [31:0] slices when word=1:
  - ZERO: divisor == 0.
  - OVF: signed, dividend is the most-negative value, divisor is all-ones.
  - HIT: cache valid and {src1, src2, word, op[0]} match the cache tag.
  - MISS: none of the above.
- ZERO, OVF and HIT go IDLE→DONE. MISS goes IDLE→ISSUE.
- ZERO result: quotient = all-ones; remainder = dividend.
- OVF result: quotient = dividend; remainder = 0.
- ISSUE: div_valid=1. On div_valid && div_ready go to WAIT; div_valid drops the next cycle.
- WAIT: on div_out_valid, capture the quotient or remainder per op[1], write the cache, go to DONE.
- Cache write: tag = {src1, src2, word, op[0]}; data = both the quotient and the remainder.
- W results: out_data = sign-extension of the selected value's bits [31:0]. This applies to every path, DIVUW/REMUW included.
- DONE: out_valid=1. out_data and out_rd are held stable until out_valid && out_ready, then go to IDLE.
- Cache lookups when CACHE_EN=1; ZERO/OVF results never write the cache.
- Cache lifetime: written only on WAIT completion. Invalidated only by reset; flush keeps it.
- Flush rules:
  - IDLE: the request in the same cycle is dropped.
  - ISSUE: go to IDLE, no divider handshake.
  - WAIT: go to DRAIN. DRAIN holds in_ready=0 until div_out_valid, discards the result without a cache write, then goes to IDLE.
  - DONE: drop the result, go to IDLE.
  - DRAIN: no effect.
- Priority: flush over out_ready; flush over div_out_valid.
- Reset (rst=0) in any state:
  - State → IDLE.
  - out_valid, div_valid, div_divw, div_signed = 0.
  - out_data, out_rd, div_dividend, div_divisor = 0.
  - Cache invalid.
  - The divider is reset by the same system reset.

## Timing
- Reset values: in_ready=1 in the first cycle after reset; every other output is 0.
- Request accepted at edge N:
  - ZERO/OVF/HIT: out_valid at N+1; div_valid never asserted.
  - MISS: div_valid high in cycle N+1. With div_ready=1 the divider accepts at edge N+1. div_out_valid arrives 32 (W) or 64 cycles later. out_valid rises the cycle after the div_out_valid cycle.
- in_ready is low from N+1 until the cycle after the out handshake. No back-to-back acceptance in the handshake cycle.
- div_valid is never asserted outside ISSUE.
- A div_out_valid pulse seen outside WAIT/DRAIN is ignored.

## Test plan
- DIV -7/2 → out_data 0xFFFFFFFFFFFFFFFD after the divider round-trip. Then REM -7/2 → 0xFFFFFFFFFFFFFFFF one cycle after accept, with div_valid never asserted.
- Divide by zero:
  - DIVU 0x1234/0 → 0xFFFFFFFFFFFFFFFF at N+1.
  - REMW src1=0x00000000_00000005, src2=0 → 0x5.
  - div_valid stays 0 throughout.
- Signed overflow:
  - DIV 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF → 0x8000000000000000.
  - DIVW 0x80000000 / 0xFFFFFFFF → 0xFFFFFFFF80000000.
  - REMW with the same operands → 0.
- DIVUW 0xFFFFFFFF/1 → 0xFFFFFFFFFFFFFFFF via the divider with div_divw=1, out_valid about 33 cycles after ISSUE. Hold out_ready=0 for 10 cycles → out_data and out_rd stable; in_ready=0.
- Flush during WAIT:
  - State goes to DRAIN with in_ready=0 until the divider's pulse; out_valid never asserts.
  - The next REM on the same operands is a miss (div_valid asserts).
- rst=0 during WAIT → next cycle in_ready=1 and all other outputs 0. The following DIV 100/7 → 14.
